// File: rtl/msg_sequencer.sv
// Message sequencer: stores NUM_MSG short messages and streams a selected one
// element by element to a UART transmitter, optionally looping until aborted.
module msg_sequencer #(
    parameter  int DATA_W  = 8,
    parameter  int MAX_LEN = 16,
    parameter  int NUM_MSG = 4,
    localparam int IDX_W   = $clog2(MAX_LEN),
    localparam int SEL_W   = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_msg,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              len_we,
    input  logic [SEL_W-1:0]  len_msg,
    input  logic [LEN_W-1:0]  len_val,
    input  logic              start,
    input  logic [SEL_W-1:0]  msg_sel,
    input  logic              repeat_en,
    input  logic              abort,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  cur_idx
);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} state_t;

    logic [DATA_W-1:0] mem [NUM_MSG][MAX_LEN];

    logic [LEN_W-1:0]  len_mem_q [NUM_MSG];
    logic [LEN_W-1:0]  len_mem_d [NUM_MSG];

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  msg_q, msg_d;
    logic              rep_q, rep_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              last_elem;

    // The element buffer carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_msg][wr_addr] <= wr_data;
        end
    end

    always_comb begin
        len_mem_d = len_mem_q;
        if (len_we) begin
            len_mem_d[len_msg] = (len_val > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_val;
        end
    end

    assign last_elem = ((LEN_W'(idx_q) + LEN_W'(1)) == len_q);

    always_comb begin
        state_d   = state_q;
        msg_d     = msg_q;
        rep_d     = rep_q;
        len_d     = len_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    msg_d   = msg_sel;
                    rep_d   = repeat_en;
                    len_d   = len_mem_q[msg_sel];
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (len_q == '0) begin
                    state_d = FIN;
                end else begin
                    tx_data_d = mem[msg_q][idx_q];
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (last_elem) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            FIN: begin
                if (rep_q) begin
                    len_d   = len_mem_q[msg_q];
                    idx_d   = '0;
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over any handshake and suppresses the done pulse.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end

        tx_valid_d = (state_d == SEND);
        done_d     = (state_d == FIN);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            msg_q      <= '0;
            rep_q      <= 1'b0;
            len_q      <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < NUM_MSG; i++) begin
                len_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            rep_q      <= rep_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            len_mem_q  <= len_mem_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cur_idx  = idx_q;

endmodule

// File: tb/tb_msg_sequencer.sv
// Directed bench for msg_sequencer: streaming, back-pressure, empty messages,
// looping with abort, ignored restarts, length saturation and mid-pass reset.
module tb_msg_sequencer;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_msg;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       len_we;
    logic [1:0] len_msg;
    logic [4:0] len_val;
    logic       start;
    logic [1:0] msg_sel;
    logic       repeat_en;
    logic       abort;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic [3:0] cur_idx;

    int checks = 0;
    int errors = 0;

    logic [7:0] msg0 [4];

    msg_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_msg    (wr_msg),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .len_we    (len_we),
        .len_msg   (len_msg),
        .len_val   (len_val),
        .start     (start),
        .msg_sel   (msg_sel),
        .repeat_en (repeat_en),
        .abort     (abort),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done),
        .cur_idx   (cur_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_elem(input logic [1:0] m, input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_msg = m; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic set_len(input logic [1:0] m, input logic [4:0] l);
        len_we = 1'b1; len_msg = m; len_val = l;
        tick();
        len_we = 1'b0;
    endtask

    task automatic apply_start(input logic [1:0] sel, input logic rep);
        start = 1'b1; msg_sel = sel; repeat_en = rep;
        tick();
        start = 1'b0; repeat_en = 1'b0;
    endtask

    initial begin
        msg0[0] = 8'h68; msg0[1] = 8'h69; msg0[2] = 8'h74; msg0[3] = 8'h73;
        rst = 1'b1; wr_en = 1'b0; wr_msg = '0; wr_addr = '0; wr_data = '0;
        len_we = 1'b0; len_msg = '0; len_val = '0; start = 1'b0; msg_sel = '0;
        repeat_en = 1'b0; abort = 1'b0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_valid", 32'(tx_valid), 32'h0);
        check_output("rst_data", 32'(tx_data), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);
        check_output("rst_done", 32'(done), 32'h0);
        check_output("rst_idx", 32'(cur_idx), 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) write_elem(2'd0, 4'(i), msg0[i]);
        set_len(2'd0, 5'd4);
        write_elem(2'd1, 4'd0, 8'h31);
        write_elem(2'd1, 4'd1, 8'h32);
        set_len(2'd1, 5'd2);
        set_len(2'd2, 5'd0);

        // Free-flowing send of msg0
        tx_ready = 1'b1;
        apply_start(2'd0, 1'b0);
        check_output("t1_fetch_busy", 32'(busy), 32'h1);
        check_output("t1_fetch_valid", 32'(tx_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("t1_valid", 32'(tx_valid), 32'h1);
            check_output("t1_data", 32'(tx_data), 32'(msg0[i]));
            check_output("t1_idx", 32'(cur_idx), 32'(i));
            tick();
            check_output("t1_gap_valid", 32'(tx_valid), 32'h0);
            check_output("t1_done", 32'(done), (i == 3) ? 32'h1 : 32'h0);
        end
        tick();
        check_output("t1_end_busy", 32'(busy), 32'h0);
        check_output("t1_end_done", 32'(done), 32'h0);

        // Back-pressure on element 1
        apply_start(2'd0, 1'b0);
        tick();
        check_output("t2_e0_data", 32'(tx_data), 32'h68);
        tick();
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_output("t2_hold_valid", 32'(tx_valid), 32'h1);
            check_output("t2_hold_data", 32'(tx_data), 32'h69);
            check_output("t2_hold_idx", 32'(cur_idx), 32'h1);
        end
        tick();
        check_output("t2_hold_last", 32'(tx_data), 32'h69);
        tx_ready = 1'b1;
        tick();
        check_output("t2_gap", 32'(tx_valid), 32'h0);
        tick();
        check_output("t2_e2_data", 32'(tx_data), 32'h74);
        tick();
        tick();
        check_output("t2_e3_data", 32'(tx_data), 32'h73);
        tick();
        check_output("t2_done", 32'(done), 32'h1);
        tick();
        check_output("t2_idle", 32'(busy), 32'h0);

        // Empty message
        apply_start(2'd2, 1'b0);
        check_output("t3_valid1", 32'(tx_valid), 32'h0);
        check_output("t3_done1", 32'(done), 32'h0);
        tick();
        check_output("t3_valid2", 32'(tx_valid), 32'h0);
        check_output("t3_done2", 32'(done), 32'h1);
        tick();
        check_output("t3_idle", 32'(busy), 32'h0);

        // Repeat mode, then abort racing a handshake
        apply_start(2'd1, 1'b1);
        for (int p = 0; p < 2; p++) begin
            tick();
            check_output("t4_e0", 32'(tx_data), 32'h31);
            check_output("t4_e0_valid", 32'(tx_valid), 32'h1);
            tick();
            tick();
            check_output("t4_e1", 32'(tx_data), 32'h32);
            tick();
            check_output("t4_done", 32'(done), 32'h1);
            tick();
            check_output("t4_reload_done", 32'(done), 32'h0);
            check_output("t4_reload_busy", 32'(busy), 32'h1);
        end
        tick();
        check_output("t4_e0_again", 32'(tx_data), 32'h31);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("t4_abort_valid", 32'(tx_valid), 32'h0);
        check_output("t4_abort_busy", 32'(busy), 32'h0);
        check_output("t4_abort_done", 32'(done), 32'h0);
        tick();
        check_output("t4_after_done", 32'(done), 32'h0);

        // Restart while busy is ignored
        apply_start(2'd0, 1'b0);
        tick();
        check_output("t5_e0", 32'(tx_data), 32'h68);
        start = 1'b1; msg_sel = 2'd1; repeat_en = 1'b1;
        tick();
        start = 1'b0; repeat_en = 1'b0;
        check_output("t5_gap_idx", 32'(cur_idx), 32'h1);
        tick();
        check_output("t5_e1", 32'(tx_data), 32'h69);
        tick();
        tick();
        check_output("t5_e2", 32'(tx_data), 32'h74);
        tick();
        tick();
        check_output("t5_e3", 32'(tx_data), 32'h73);
        tick();
        check_output("t5_done", 32'(done), 32'h1);
        tick();
        check_output("t5_idle", 32'(busy), 32'h0);

        // Oversized length saturates to a full 16-element message
        for (int i = 0; i < 16; i++) write_elem(2'd3, 4'(i), 8'(8'h40 + i));
        set_len(2'd3, 5'd20);
        apply_start(2'd3, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick();
            check_output("t6_data", 32'(tx_data), 32'(8'h40 + i));
            check_output("t6_idx", 32'(cur_idx), 32'(i));
            tick();
        end
        check_output("t6_done", 32'(done), 32'h1);
        check_output("t6_valid", 32'(tx_valid), 32'h0);

        // Reset mid-pass
        tick();
        apply_start(2'd0, 1'b0);
        tick();
        check_output("t7_presend", 32'(tx_valid), 32'h1);
        rst = 1'b1;
        #1;
        check_output("t7_rst_valid", 32'(tx_valid), 32'h0);
        check_output("t7_rst_data", 32'(tx_data), 32'h0);
        check_output("t7_rst_busy", 32'(busy), 32'h0);
        check_output("t7_rst_idx", 32'(cur_idx), 32'h0);
        tick();
        check_output("t7_rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        tick();
        apply_start(2'd0, 1'b0);
        check_output("t7_new_valid1", 32'(tx_valid), 32'h0);
        check_output("t7_new_busy", 32'(busy), 32'h1);
        tick();
        check_output("t7_new_valid2", 32'(tx_valid), 32'h0);
        check_output("t7_new_done", 32'(done), 32'h1);
        tick();
        check_output("t7_new_idle", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msg_sequencer.md
MSG_SEQUENCER -- requirements
Module: msg_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning byte width of each message element.
REQ-002 SHALL have parameter MAX_LEN, default 16, meaning maximum elements per message, power of two, at least 2.
REQ-003 SHALL have parameter NUM_MSG, default 4, meaning number of stored messages, power of two, at least 1.
REQ-004 SHALL derive IDX_W=clog2(MAX_LEN), SEL_W=max(1,clog2(NUM_MSG)) and LEN_W=clog2(MAX_LEN+1).
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-006 SHALL have ports: wr_en in 1 buffer write strobe; wr_msg in SEL_W target message; wr_addr in IDX_W element index; wr_data in DATA_W element value.
REQ-007 SHALL have ports: len_we in 1 length write strobe; len_msg in SEL_W target message; len_val in LEN_W length.
REQ-008 SHALL have ports: start in 1 send request; msg_sel in SEL_W message to send; repeat_en in 1 loop mode; abort in 1 stop request.
REQ-009 SHALL have ports: tx_data out DATA_W element to UART TX; tx_valid out 1 element valid; tx_ready in 1 TX accepts element.
REQ-010 SHALL have ports: busy out 1 sequence active; done out 1 one-cycle end-of-pass pulse; cur_idx out IDX_W index of presented element.

Function
REQ-011 SHALL store NUM_MSG x MAX_LEN elements, written synchronously when wr_en=1, at any time, including while busy.
REQ-012 SHALL hold one LEN_W length register per message, written when len_we=1; len_val>MAX_LEN SHALL be saturated to MAX_LEN.
REQ-013 SHALL implement states IDLE, FETCH, SEND, FIN.
REQ-014 IDLE: start=1 SHALL latch msg_sel, repeat_en and that message's length, clear the index and go to FETCH; start while not IDLE SHALL be ignored.
REQ-015 FETCH: latched length 0 SHALL go to FIN without asserting tx_valid; otherwise SHALL register tx_data from buffer[msg][idx] and go to SEND.
REQ-016 SEND: tx_valid=1 and tx_data, cur_idx SHALL stay stable until the cycle with tx_ready=1.
REQ-017 SEND handshake on a non-last element SHALL increment the index and go to FETCH, so tx_valid is low for exactly one cycle between elements.
REQ-018 SEND handshake on element length-1 SHALL go to FIN.
REQ-019 FIN SHALL pulse done=1 for one cycle; with latched repeat=0 it SHALL go to IDLE, with repeat=1 it SHALL reload the length, clear the index and go to FETCH.
REQ-020 Latency: start in cycle N SHALL give tx_valid=1 in cycle N+2; last handshake in cycle M SHALL give done=1 in cycle M+1.
REQ-021 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, drop tx_valid, and not pulse done; abort has priority over tx_ready in the same cycle.
REQ-022 busy SHALL be 1 in FETCH, SEND and FIN, and 0 in IDLE.
REQ-023 Writes to the active message's elements SHALL affect only elements not yet fetched; a length write during a pass SHALL take effect at the next start or repeat reload.
REQ-024 Index arithmetic SHALL be IDX_W wide with no wrap past length-1.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, tx_valid=0, tx_data=0, busy=0, done=0, cur_idx=0, all length registers 0, and latched selection and repeat 0.
REQ-026 The element buffer SHALL NOT be reset; its contents are undefined after power-up.
REQ-027 rst asserted mid-pass SHALL terminate the pass with no done pulse.

Verification
REQ-028 Load msg0 = 68 69 74 73, len 4; start with msg_sel=0 and tx_ready tied 1 -> tx_data 68,69,74,73 each valid one cycle with one-cycle gaps, then done in the cycle after the last element, busy falls.
REQ-029 Same load; tx_ready held 0 for 5 cycles on element 1 -> tx_valid=1, tx_data=69 and cur_idx=1 stay stable for all 5 cycles.
REQ-030 len 0 on msg2, then start -> no tx_valid, done pulse 2 cycles after start.
REQ-031 repeat_en=1 on msg1 = 31 32, len 2 -> sequence 31 32 31 32..., done every pass; abort during SEND -> tx_valid 0 next cycle, busy 0, no done.
REQ-032 start while busy with a different msg_sel -> ignored, the current message completes unchanged; len_val=20 -> stored as 16.
REQ-033 rst asserted during SEND -> all outputs 0 immediately; a new start after reset produces no element, because the length registers are 0.
